sram_burst_reader: RTL and testbench
====================================

SRAM_BURST_READER -- requirements
Module: sram_burst_reader

Interface
REQ-001 Parameter XLEN, default 32, data word width in bits.
REQ-002 Parameter N_ENTRIES, default 1024, SRAM depth in words; AW = $clog2(N_ENTRIES).
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 start_i  input  1  burst request; sampled only in IDLE.
REQ-006 base_addr_i  input  AW  first SRAM word address of the burst.
REQ-007 len_i  input  AW+1  burst length in words, 0..N_ENTRIES.
REQ-008 busy_o  output  1  high while a burst is in progress.
REQ-009 done_o  output  1  one-cycle pulse at burst completion.
REQ-010 sram_en_o  output  1  SRAM port enable; high only in cycles that issue a read.
REQ-011 sram_we_o  output  1  SRAM write enable; constant 0.
REQ-012 sram_addr_o  output  AW  SRAM read address.
REQ-013 sram_data_i  input  XLEN  SRAM read data, valid the cycle after sram_en_o.
REQ-014 m_data_o  output  XLEN  stream data.
REQ-015 m_valid_o  output  1  stream data valid.
REQ-016 m_ready_i  input  1  stream consumer ready; a beat transfers when m_valid_o and m_ready_i are both high.
REQ-017 m_last_o  output  1  marks the final beat of the burst; qualified by m_valid_o.

Function
REQ-018 States: IDLE, READ, DRAIN. IDLE->READ on start_i with len_i>0. READ->DRAIN after the last read is issued. DRAIN->IDLE when the last beat transfers.
REQ-019 When start_i is sampled in IDLE with len_i=0, the block shall stay in IDLE, issue no read, and pulse done_o the next cycle.
REQ-020 While busy_o=1, start_i shall be ignored; base_addr_i and len_i shall be latched only at acceptance.
REQ-021 The first read shall issue in the cycle after start_i is sampled, with sram_addr_o=base_addr_i.
REQ-022 Each subsequent read address shall increment by 1 modulo N_ENTRIES, wrapping from N_ENTRIES-1 to 0.
REQ-023 Read data shall be captured from sram_data_i the cycle after issue into a 2-entry output FIFO; m_data_o, m_valid_o and m_last_o shall be driven from the FIFO head.
REQ-024 A read shall issue only when (FIFO count + reads in flight − pop this cycle) < 2. A combinational path from m_ready_i to sram_en_o is permitted.
REQ-025 FIFO overflow shall never occur; data order shall equal address order.
REQ-026 With m_ready_i held high, throughput shall be 1 word per cycle.
REQ-027 First m_valid_o shall assert 3 cycles after the clock edge that samples start_i.
REQ-028 m_data_o, m_valid_o and m_last_o shall hold stable while m_valid_o=1 and m_ready_i=0.
REQ-029 Exactly len_i beats shall be produced, and m_last_o shall be high only on the len_i-th beat.
REQ-030 done_o shall pulse in the cycle after the last beat transfers, when busy_o falls.
REQ-031 A new start_i may be accepted in the cycle done_o is high.
REQ-032 busy_o shall be high from the cycle after start acceptance through the cycle of the last beat transfer.

Reset
REQ-033 While rst_i=1, the block shall enter IDLE and clear the FIFO, in-flight flag, counters and the done pulse.
REQ-034 During and after reset: busy_o=0, done_o=0, sram_en_o=0, sram_we_o=0, sram_addr_o=0, m_valid_o=0, m_last_o=0, m_data_o=0.
REQ-035 Reset asserted mid-burst shall abort the burst with no further beats and no done_o pulse; SRAM data returning after reset shall be discarded.

Verification
REQ-036 SRAM preloaded with mem[a]=a+0x100, base=5, len=4, m_ready_i=1: beats 0x105,0x106,0x107,0x108 on consecutive cycles, m_last_o on 0x108, done_o the following cycle.
REQ-037 N_ENTRIES=1024, base=1022, len=4: addresses 1022,1023,0,1 in order.
REQ-038 base=0, len=8, m_ready_i toggled 1,0,0,1,0,1,...: 8 beats in order; data held while stalled; never more than 2 words buffered plus in flight; sram_en_o=0 while the FIFO is full.
REQ-039 len=0: no sram_en_o assertion, done_o one cycle after start, busy_o stays 0.
REQ-040 rst_i pulsed 1 cycle after the 3rd beat of a len=10 burst: no further beats, no done_o; a new start with base=0, len=2 then completes normally.
REQ-041 start_i held high during a burst: second burst not started; after done_o, the start_i still high in the done_o cycle is accepted.

Source files
------------

// File: rtl/sram_burst_reader.sv
// sram_burst_reader
//   Reads len_i consecutive words from a single-port synchronous SRAM,
//   starting at base_addr_i and wrapping modulo N_ENTRIES. The words are
//   streamed out on a valid/ready interface through a 2-entry FIFO.
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   start_i, base_addr_i,
//   len_i                      burst request (sampled only when idle)
//   busy_o, done_o             burst in progress / one-cycle completion pulse
//   sram_en_o, sram_we_o,
//   sram_addr_o, sram_data_i   SRAM read port (data one cycle after enable)
//   m_data_o, m_valid_o,
//   m_ready_i, m_last_o        output stream
module sram_burst_reader #(
  parameter int XLEN      = 32,
  parameter int N_ENTRIES = 1024,
  localparam int AW       = $clog2(N_ENTRIES)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [AW-1:0]   base_addr_i,
  input  logic [AW:0]     len_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            sram_en_o,
  output logic            sram_we_o,
  output logic [AW-1:0]   sram_addr_o,
  input  logic [XLEN-1:0] sram_data_i,
  output logic [XLEN-1:0] m_data_o,
  output logic            m_valid_o,
  input  logic            m_ready_i,
  output logic            m_last_o
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t          r_state, w_next;
  logic [AW-1:0]   r_addr;
  logic [AW:0]     r_issue_left;   // reads still to issue
  logic [AW:0]     r_beats_left;   // beats still to transfer
  logic            r_inflight;     // read issued last cycle, data on sram_data_i now
  logic [XLEN-1:0] r_mem [2];
  logic            r_wp, r_rp;
  logic [1:0]      r_cnt;
  logic            r_done;

  logic            w_pop, w_issue, w_accept, w_zero_start, w_last_pop;
  logic [2:0]      w_occ;

  assign m_valid_o   = (r_cnt != 2'd0);
  assign m_data_o    = r_mem[r_rp];
  assign m_last_o    = m_valid_o && (r_beats_left == (AW+1)'(1));
  assign w_pop       = m_valid_o && m_ready_i;
  assign w_last_pop  = w_pop && (r_beats_left == (AW+1)'(1));
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign sram_we_o   = 1'b0;
  assign sram_addr_o = r_addr;
  assign sram_en_o   = w_issue;

  // Words buffered plus the one in flight, minus the one leaving this cycle.
  // A pop implies r_cnt >= 1, so this never underflows.
  assign w_occ = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

  always_comb begin
    w_next       = r_state;
    w_issue      = 1'b0;
    w_accept     = 1'b0;
    w_zero_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && (len_i != '0)) begin
          w_accept = 1'b1;
          w_next   = S_READ;
        end else if (start_i) begin
          w_zero_start = 1'b1;
        end
      end
      S_READ: begin
        w_issue = !rst_i && (w_occ < 3'd2);
        if (w_issue && (r_issue_left == (AW+1)'(1))) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_last_pop) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_beats_left <= '0;
      r_inflight   <= 1'b0;
      r_mem[0]     <= '0;
      r_mem[1]     <= '0;
      r_wp         <= 1'b0;
      r_rp         <= 1'b0;
      r_cnt        <= 2'd0;
      r_done       <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_done     <= w_zero_start || ((r_state == S_DRAIN) && w_last_pop);
      r_inflight <= w_issue;
      if (w_accept) begin
        r_addr       <= base_addr_i;
        r_issue_left <= len_i;
        r_beats_left <= len_i;
      end else begin
        if (w_issue) begin
          r_addr       <= (r_addr == AW'(N_ENTRIES-1)) ? '0 : r_addr + AW'(1);
          r_issue_left <= r_issue_left - (AW+1)'(1);
        end
        if (w_pop) r_beats_left <= r_beats_left - (AW+1)'(1);
      end
      // Capture the word read last cycle; the credit rule guarantees room.
      if (r_inflight) begin
        r_mem[r_wp] <= sram_data_i;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_sram_burst_reader.sv
module tb_sram_burst_reader;
  localparam int N = 1024;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, m_ready_i;
  logic [9:0]  base_addr_i;
  logic [10:0] len_i;
  logic        busy_o, done_o, sram_en_o, sram_we_o, m_valid_o, m_last_o;
  logic [9:0]  sram_addr_o;
  logic [31:0] sram_data_i, m_data_o;

  sram_burst_reader #(.XLEN(32), .N_ENTRIES(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .sram_en_o(sram_en_o),
    .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o), .sram_data_i(sram_data_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o)
  );

  always #5 clk_i = ~clk_i;

  // SRAM model: data one cycle after enable, garbage otherwise.
  logic [31:0] mem [N];
  always @(posedge clk_i) sram_data_i <= sram_en_o ? mem[sram_addr_o] : $urandom;

  int checks = 0, errors = 0;

  // Reference model: per-burst list of expected words/addresses.
  logic [31:0] exp_data_q[$];
  int          exp_addr_q[$];
  bit          m_busy, m_done, first_pend, first_iss_pend, prev_stall, thru_chk;
  logic [31:0] prev_data;
  logic        prev_last;
  int          iss, pops, since, cyc, last_pop_cyc, beat_idx, acc_cnt;
  int          rmode, rk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] ex);
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
    end
  endtask

  task automatic clear_model();
    exp_data_q.delete(); exp_addr_q.delete();
    m_busy = 0; m_done = 0; first_pend = 0; first_iss_pend = 0; prev_stall = 0;
    iss = 0; pops = 0;
  endtask

  task automatic drive_ready();
    case (rmode)
      0: m_ready_i = 1'b1;
      1: m_ready_i = 1'($urandom_range(0, 1));
      default: begin
        case (rk % 6)
          0, 3, 5: m_ready_i = 1'b1;
          default: m_ready_i = 1'b0;
        endcase
        rk++;
      end
    endcase
  endtask

  task automatic tick();
    bit en, pop, acc, last_beat, done_n;
    int a;
    @(negedge clk_i);
    en  = sram_en_o;
    pop = m_valid_o && m_ready_i;
    if (!rst_i) begin
      chk("we_zero", sram_we_o, 0);
      chk("busy", busy_o, m_busy);
      chk("done", done_o, m_done);
      chk("occupancy_le2", (iss - pops) <= 2, 1);
      if (en) begin
        chk("en_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) chk("addr", sram_addr_o, exp_addr_q[0]);
        chk("credit", (iss - pops - int'(pop)) < 2, 1);
      end
      if (first_iss_pend && since == 1) begin
        chk("first_issue", en, 1);
        first_iss_pend = 0;
      end
      if (prev_stall) begin
        chk("hold_valid", m_valid_o, 1);
        chk("hold_data", m_data_o, prev_data);
        chk("hold_last", m_last_o, prev_last);
      end
      if (m_valid_o) begin
        chk("valid_expected", exp_data_q.size() != 0, 1);
        if (exp_data_q.size() != 0) begin
          chk("data", m_data_o, exp_data_q[0]);
          chk("last", m_last_o, exp_data_q.size() == 1);
        end
        if (first_pend) begin
          chk("latency", since, 3);
          first_pend = 0;
        end
      end
      if (pop && thru_chk && beat_idx > 0) chk("throughput", cyc - last_pop_cyc, 1);
      if (pop) last_pop_cyc = cyc;
    end
    prev_stall = !rst_i && m_valid_o && !m_ready_i;
    prev_data  = m_data_o;
    prev_last  = m_last_o;
    acc = start_i && !m_busy && !rst_i;
    @(posedge clk_i);
    cyc++;
    if (rst_i) begin
      clear_model();
    end else begin
      since++;
      done_n = 0;
      last_beat = 0;
      if (en) begin
        iss++;
        if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
      end
      if (pop) begin
        pops++;
        beat_idx++;
        if (exp_data_q.size() != 0) begin
          last_beat = (exp_data_q.size() == 1);
          void'(exp_data_q.pop_front());
        end
        if (last_beat) begin m_busy = 0; done_n = 1; end
      end
      if (acc) begin
        acc_cnt++;
        if (len_i == 0) done_n = 1;
        else begin
          m_busy = 1; since = 1; first_pend = 1; first_iss_pend = 1; beat_idx = 0;
          for (int i = 0; i < int'(len_i); i++) begin
            a = (int'(base_addr_i) + i) % N;
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem[a]);
          end
        end
      end
      m_done = done_n;
    end
    #1;
  endtask

  task automatic chk_zero();
    chk("rst_busy", busy_o, 0);   chk("rst_done", done_o, 0);
    chk("rst_en", sram_en_o, 0);  chk("rst_we", sram_we_o, 0);
    chk("rst_addr", sram_addr_o, 0); chk("rst_valid", m_valid_o, 0);
    chk("rst_last", m_last_o, 0); chk("rst_data", m_data_o, 0);
  endtask

  task automatic burst(int b, int l);
    start_i = 1'b1; base_addr_i = 10'(b); len_i = 11'(l);
    drive_ready();
    tick();
    start_i = 1'b0; base_addr_i = 10'($urandom); len_i = 11'($urandom);
  endtask

  task automatic wait_idle(int max);
    int n = 0;
    while ((m_busy || m_done) && n < max) begin
      drive_ready();
      tick();
      n++;
    end
    chk("timeout", n < max, 1);
  endtask

  initial begin
    for (int a = 0; a < N; a++) mem[a] = 32'(a + 32'h100);
    cyc = 0; since = 0; beat_idx = 0; acc_cnt = 0; rmode = 0; rk = 0;
    thru_chk = 0; last_pop_cyc = 0; prev_data = '0; prev_last = 0;
    clear_model();
    rst_i = 1; start_i = 0; base_addr_i = 0; len_i = 0; m_ready_i = 1;
    repeat (3) tick();
    chk_zero();
    rst_i = 0;
    tick();

    // base 5, len 4, ready high: 0x105..0x108 back to back
    thru_chk = 1; rmode = 0;
    burst(5, 4);
    wait_idle(40);
    thru_chk = 0;

    // address wrap 1022,1023,0,1
    burst(1022, 4);
    wait_idle(40);

    // stalls with ready pattern 1,0,0,1,0,1
    rmode = 2; rk = 0;
    burst(0, 8);
    wait_idle(80);

    // zero length: no reads, done next cycle, never busy
    rmode = 0;
    burst(77, 0);
    wait_idle(10);
    repeat (2) tick();

    // reset one cycle after third beat of a len=10 burst
    rmode = 0;
    burst(0, 10);
    begin
      int n = 0;
      while (beat_idx < 3 && n < 40) begin tick(); n++; end
      chk("beat3_timeout", n < 40, 1);
    end
    tick();
    rst_i = 1;
    tick();
    chk_zero();
    rst_i = 0;
    repeat (6) tick();
    burst(0, 2);
    wait_idle(40);

    // start held high across a burst and into its done cycle
    acc_cnt = 0;
    start_i = 1; base_addr_i = 20; len_i = 3;
    begin
      int n = 0;
      while (acc_cnt < 2 && n < 60) begin tick(); n++; end
      chk("restart_timeout", n < 60, 1);
    end
    start_i = 0;
    wait_idle(40);

    // randomized bursts over random memory contents
    for (int a = 0; a < N; a++) mem[a] = $urandom;
    rmode = 1;
    for (int t = 0; t < 25; t++) begin
      int l;
      l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 16));
      burst(int'($urandom_range(0, N-1)), l);
      wait_idle(200);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
